// File: rtl/registers.sv
// 16 x 32-bit register bank: two combinational read ports, one synchronous write port.
// Define REGBANK_WRITE_BYPASS_EN to forward write data to a read port in the same cycle.
module registers #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] data,
    input  logic              write,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   w_we;
    logic [DATA_W-1:0] w_rd1_stored;
    logic [DATA_W-1:0] w_rd2_stored;

    // Enable is gated by write first, so X on rd/data with write=0 cannot reach state.
    for (genvar g = 0; g < NREG; g++) begin : g_reg
        assign w_we[g] = write && (rd == ADDR_W'(g));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_regs[g] <= '0;
            else if (w_we[g])
                r_regs[g] <= data;
        end
    end

    assign w_rd1_stored = r_regs[rs];
    assign w_rd2_stored = r_regs[rt];

`ifdef REGBANK_WRITE_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    assign w_byp1 = write && rst_n && (rs == rd);
    assign w_byp2 = write && rst_n && (rt == rd);
    assign rd1    = w_byp1 ? data : w_rd1_stored;
    assign rd2    = w_byp2 ? data : w_rd2_stored;
`else
    assign rd1 = w_rd1_stored;
    assign rd2 = w_rd2_stored;
`endif

endmodule

// File: tb/tb_registers.sv
// Scoreboard bench for the register bank; bypass checks follow REGBANK_WRITE_BYPASS_EN.
module tb_registers;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rs = '0, rt = '0, rd = '0;
    logic [31:0] data = '0;
    logic        write = 1'b0;
    logic [31:0] rd1, rd2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [16];

    registers #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd),
        .data(data), .write(write), .rd1(rd1), .rd2(rd2)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.tag = tag; e.e1 = e1; e.e2 = e2;
        sb.push_back(e);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        rd = a; data = d; write = 1'b1;
        @(posedge clk);
        model[a] = d;
        #1 write = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        for (int i = 0; i < 16; i++) model[i] = '0;
        rs = 4'd5; rt = 4'd15;
        #1 push_exp("reset_held", 32'h0, 32'h0);
        e = sb.pop_front();
        n_checks += 2;
        if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s rd1: got %h want %h", e.tag, rd1, e.e1); end
        if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s rd2: got %h want %h", e.tag, rd2, e.e2); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        push_exp("reset_released", 32'h0, 32'h0);
        e = sb.pop_front();
        n_checks += 2;
        if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s rd1: got %h want %h", e.tag, rd1, e.e1); end
        if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s rd2: got %h want %h", e.tag, rd2, e.e2); end
    endtask

    task automatic test_write;
        exp_t e;
        do_write(4'd0, 32'd234);
        rs = 4'd0; rt = 4'd3;
        push_exp("write_r0", 32'd234, 32'd0);
        #1 e = sb.pop_front();
        n_checks += 2;
        if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s rd1: got %h want %h", e.tag, rd1, e.e1); end
        if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s rd2: got %h want %h", e.tag, rd2, e.e2); end
        do_write(4'd3, 32'd340);
        push_exp("write_r3", 32'd234, 32'd340);
        #1 e = sb.pop_front();
        n_checks += 2;
        if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s rd1: got %h want %h", e.tag, rd1, e.e1); end
        if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s rd2: got %h want %h", e.tag, rd2, e.e2); end
    endtask

    task automatic test_write_disable;
        exp_t e;
        @(negedge clk);
        rd = 4'd3; data = 32'd999; write = 1'b0;
        @(posedge clk);
        // X on address/data with write low must not disturb any register
        #1 rd = 'x; data = 'x;
        @(posedge clk); #1;
        rd = '0; data = '0;
        rs = 4'd0; rt = 4'd3;
        push_exp("write_disabled", 32'd234, 32'd340);
        #1 e = sb.pop_front();
        n_checks += 2;
        if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s rd1: got %h want %h", e.tag, rd1, e.e1); end
        if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s rd2: got %h want %h", e.tag, rd2, e.e2); end
    endtask

    task automatic test_dual_read;
        exp_t e;
        rs = 4'd3; rt = 4'd3;
        push_exp("same_addr_r3", 32'd340, 32'd340);
        #1 e = sb.pop_front();
        n_checks += 2;
        if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s rd1: got %h want %h", e.tag, rd1, e.e1); end
        if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s rd2: got %h want %h", e.tag, rd2, e.e2); end
        do_write(4'd15, 32'hFFFF_FFFF);
        rs = 4'd15; rt = 4'd15;
        push_exp("same_addr_r15", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #1 e = sb.pop_front();
        n_checks += 2;
        if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s rd1: got %h want %h", e.tag, rd1, e.e1); end
        if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s rd2: got %h want %h", e.tag, rd2, e.e2); end
    endtask

    task automatic test_same_cycle;
        exp_t e;
        @(negedge clk);
        rd = 4'd7; rs = 4'd7; rt = 4'd0; data = 32'd55; write = 1'b1;
`ifdef REGBANK_WRITE_BYPASS_EN
        push_exp("bypass_pre_edge", 32'd55, model[0]);
`else
        push_exp("no_bypass_pre_edge", model[7], model[0]);
`endif
        #1 e = sb.pop_front();
        n_checks += 2;
        if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s rd1: got %h want %h", e.tag, rd1, e.e1); end
        if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s rd2: got %h want %h", e.tag, rd2, e.e2); end
        @(posedge clk);
        model[7] = 32'd55;
        #1 write = 1'b0;
        push_exp("post_edge_r7", 32'd55, model[0]);
        #1 e = sb.pop_front();
        n_checks += 2;
        if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s rd1: got %h want %h", e.tag, rd1, e.e1); end
        if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s rd2: got %h want %h", e.tag, rd2, e.e2); end
    endtask

    task automatic test_random;
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            write = 1'($urandom_range(0, 1));
            rd    = 4'($urandom_range(0, 15));
            rs    = 4'($urandom_range(0, 15));
            rt    = (i % 5 == 0) ? rd : 4'($urandom_range(0, 15));
            data  = $urandom;
`ifdef REGBANK_WRITE_BYPASS_EN
            push_exp("random_pre_edge",
                     (write && rs == rd) ? data : model[rs],
                     (write && rt == rd) ? data : model[rt]);
`else
            push_exp("random_pre_edge", model[rs], model[rt]);
`endif
            #1 e = sb.pop_front();
            n_checks += 2;
            if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s[%0d] rd1: got %h want %h", e.tag, i, rd1, e.e1); end
            if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s[%0d] rd2: got %h want %h", e.tag, i, rd2, e.e2); end
            @(posedge clk);
            if (write) model[rd] = data;
        end
        #1 write = 1'b0;
        for (int a = 0; a < 16; a++) begin
            rs = 4'(a); rt = 4'(15 - a);
            push_exp("random_sweep", model[a], model[15 - a]);
            #1 e = sb.pop_front();
            n_checks += 2;
            if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s[%0d] rd1: got %h want %h", e.tag, a, rd1, e.e1); end
            if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s[%0d] rd2: got %h want %h", e.tag, a, rd2, e.e2); end
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        do_write(4'd9, 32'hDEAD_BEEF);
        do_write(4'd2, 32'h1234_5678);
        rs = 4'd9; rt = 4'd2;
        @(negedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        push_exp("async_reset_no_edge", 32'h0, 32'h0);
        #1 e = sb.pop_front();
        n_checks += 2;
        if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s rd1: got %h want %h", e.tag, rd1, e.e1); end
        if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s rd2: got %h want %h", e.tag, rd2, e.e2); end
        // Write held across an edge while reset is low must be ignored
        rd = 4'd9; data = 32'h5555_AAAA; write = 1'b1;
        @(posedge clk); #1;
        push_exp("reset_overrides_write", 32'h0, 32'h0);
        e = sb.pop_front();
        n_checks += 2;
        if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s rd1: got %h want %h", e.tag, rd1, e.e1); end
        if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s rd2: got %h want %h", e.tag, rd2, e.e2); end
        @(negedge clk);
        write = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_exp("release_no_write", 32'h0, 32'h0);
        e = sb.pop_front();
        n_checks += 2;
        if (rd1 !== e.e1) begin n_fail++; $display("FAIL %s rd1: got %h want %h", e.tag, rd1, e.e1); end
        if (rd2 !== e.e2) begin n_fail++; $display("FAIL %s rd2: got %h want %h", e.tag, rd2, e.e2); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_write_disable();
        test_dual_read();
        test_same_cycle();
        test_random();
        test_async_reset();
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/registers.md
Name: registers

Overview:
- General-purpose register bank for the processor datapath: 16 x 32-bit registers.
- Two asynchronous (combinational) read ports feed the ALU operands, addressed by rs and rt.
- One synchronous write port is addressed by rd and used for result writeback.
- Sits between the instruction decode stage (register addresses) and the execute/writeback stages.

Parameters:
- DATA_W, 32, width of each register and of the data/read ports.
- ADDR_W, 4, width of rs/rt/rd; register count = 2**ADDR_W (16).

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears every register.
- rs  input  ADDR_W  read address, port 1.
- rt  input  ADDR_W  read address, port 2.
- rd  input  ADDR_W  write address.
- data  input  DATA_W  write data.
- write  input  1  write enable, active-high.
- rd1  output  DATA_W  contents of register[rs].
- rd2  output  DATA_W  contents of register[rt].

Behaviour:
- Reset:
  - rst_n low clears all 16 registers to 0 immediately, with no clock needed.
  - rd1 and rd2 read 0 while reset is asserted.
  - Reset mid-operation overrides any write on the same edge.
  - On rst_n deassertion, no write occurs until the next rising clk edge with write=1.
- Write:
  - On the rising edge of clk with rst_n=1 and write=1, register[rd] <= data.
  - write=0 leaves all registers unchanged.
  - Single-cycle write latency; the new value is architecturally visible after the edge.
- Read:
  - rd1 = register[rs] and rd2 = register[rt], purely combinational.
  - Zero-cycle latency from an address change to the output.
- Register 0 is an ordinary writable register; there is no hardwired zero.
- Same address on both read ports: both outputs carry the identical value.
- Read of the address being written in the same cycle, without the optional feature: the output shows the old value until the clock edge, then the new value.
- All addresses 0..15 are valid; there is no out-of-range case.
- Data is stored unmodified, with no sign extension or truncation.
- X/Z on the write inputs while write=0 must not corrupt state.

Optional Feature:
- Macro: REGBANK_WRITE_BYPASS_EN.
- Defined:
  - When write=1 and rst_n=1, rd1 = data if rs==rd, and rd2 = data if rt==rd.
  - This is combinational write-through forwarding in the same cycle, before the clock edge.
  - The stored value still updates at the edge as normal.
- Undefined:
  - No forwarding; reads always return stored register contents.
  - Same-cycle read of the register being written returns the old value.

Test Plan:
- Reset then read: assert rst_n=0, release, set rs=5, rt=15 -> rd1=0, rd2=0.
- Write r0: rd=0, data=234, write=1, one rising edge, then rs=0, rt=3 -> rd1=234, rd2=0.
- Write r3 with r0 retained: rd=3, data=340, write=1, one rising edge, rs=0, rt=3 -> rd1=234, rd2=340.
- Write disabled: write=0, rd=3, data=999, one rising edge -> rd2 still 340.
- Dual read, same address: rs=rt=3 -> rd1=rd2=340. Write 0xFFFFFFFF to r15, then rs=rt=15 -> both read 0xFFFFFFFF.
- Async reset mid-operation: registers loaded, pull rst_n low between edges -> rd1/rd2 go to 0 immediately, with no clock edge.
  - With REGBANK_WRITE_BYPASS_EN, also check: write=1, rd=rs=7, data=55 before the edge -> rd1=55 immediately.
